// File: rtl/merge2_arb_leaf.sv
// Two-input round-robin merge leaf: a captured packet leaves as a select token
// naming the winning input, followed by the unchanged packet.
module merge2_arb_leaf #(
  parameter int W        = 9,
  parameter int CNT_W    = 16,
  parameter int INIT_PRI = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [W-1:0]     in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic             s_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic [1:0] {IDLE, SEND_S, SEND_D} state_t;

  state_t             state_q, state_d;
  logic               pri_q, pri_d;
  logic               win_q, win_d;
  logic [W-1:0]       pkt_q, pkt_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic               grant;

  always_comb begin
    state_d   = state_q;
    pri_d     = pri_q;
    win_d     = win_q;
    pkt_d     = pkt_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    s_valid   = 1'b0;
    s_data    = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    grant     = (in0_valid && in1_valid) ? pri_q : in1_valid;
    // Outputs are gated by reset so nothing handshakes during the reset cycle.
    case (state_q)
      IDLE: begin
        if (!reset) begin
          in0_ready = !grant && in0_valid;
          in1_ready = grant && in1_valid;
          if (in0_ready || in1_ready) begin
            win_d   = grant;
            pkt_d   = grant ? in1_data : in0_data;
            state_d = SEND_S;
          end
        end
      end
      SEND_S: begin
        s_valid = !reset;
        s_data  = win_q && !reset;
        if (s_ready) state_d = SEND_D;
      end
      SEND_D: begin
        out_valid = !reset;
        out_data  = reset ? '0 : pkt_q;
        if (out_ready) begin
          if (win_q) cnt1_d = cnt1_q + CNT_W'(1);
          else       cnt0_d = cnt0_q + CNT_W'(1);
          pri_d   = ~win_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pri_q   <= INIT_PRI[0];
      win_q   <= 1'b0;
      pkt_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      win_q   <= win_d;
      pkt_q   <= pkt_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_merge2_arb_leaf.sv
// Directed bench for merge2_arb_leaf: per-cycle vector table plus sequences for
// contention, single-input streaming and counter wrap.
module tb_merge2_arb_leaf;
  localparam int W = 9;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic in0_valid, in1_valid, in0_ready, in1_ready;
  logic s_data, s_valid, s_ready, out_valid, out_ready;
  logic [15:0] pkt_cnt0, pkt_cnt1;

  logic [W-1:0] w_in0_data, w_in1_data, w_out_data;
  logic w_in0_valid, w_in1_valid, w_in0_ready, w_in1_ready;
  logic w_s_data, w_s_valid, w_rdy, w_out_valid;
  logic [1:0] w_cnt0, w_cnt1;

  merge2_arb_leaf #(.W(W), .CNT_W(16), .INIT_PRI(0)) u_dut (
    .clk(clk), .reset(reset),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1));

  merge2_arb_leaf #(.W(W), .CNT_W(2), .INIT_PRI(0)) u_wrap (
    .clk(clk), .reset(reset),
    .in0_data(w_in0_data), .in0_valid(w_in0_valid), .in0_ready(w_in0_ready),
    .in1_data(w_in1_data), .in1_valid(w_in1_valid), .in1_ready(w_in1_ready),
    .s_data(w_s_data), .s_valid(w_s_valid), .s_ready(w_rdy),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_rdy),
    .pkt_cnt0(w_cnt0), .pkt_cnt1(w_cnt1));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int hs = 0;

  always @(posedge clk) if (out_valid && out_ready) hs++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic rst; logic i0v; logic [8:0] i0d; logic i1v; logic [8:0] i1d;
    logic sr; logic orr;
    logic e0r; logic e1r; logic esv; logic esd; logic eov; logic [8:0] eod;
    logic [15:0] ec0; logic [15:0] ec1;
  } vec_t;

  function automatic vec_t mk(logic rst, logic i0v, logic [8:0] i0d, logic i1v,
      logic [8:0] i1d, logic sr, logic orr, logic e0r, logic e1r, logic esv,
      logic esd, logic eov, logic [8:0] eod, logic [15:0] ec0, logic [15:0] ec1);
    vec_t v;
    v.rst = rst; v.i0v = i0v; v.i0d = i0d; v.i1v = i1v; v.i1d = i1d;
    v.sr = sr; v.orr = orr; v.e0r = e0r; v.e1r = e1r; v.esv = esv;
    v.esd = esd; v.eov = eov; v.eod = eod; v.ec0 = ec0; v.ec1 = ec1;
    return v;
  endfunction

  vec_t tv[22];
  logic tok[8];
  logic [8:0] dat[8];

  initial begin
    int ntok, nout, viol, i0, i1, n0r, ncyc;
    // rst i0v i0d  i1v i1d  sr or | in0r in1r sv sd ov od   cnt0 cnt1
    tv[0]  = mk(1,1,9'h0A5,0,9'h000,1,1, 0,0,0,0,0,9'h000, 0,0);
    tv[1]  = mk(0,1,9'h0A5,0,9'h000,1,1, 1,0,0,0,0,9'h000, 0,0);
    tv[2]  = mk(0,0,9'h000,0,9'h000,1,1, 0,0,1,0,0,9'h000, 0,0);
    tv[3]  = mk(0,0,9'h000,0,9'h000,1,1, 0,0,0,0,1,9'h0A5, 0,0);
    tv[4]  = mk(0,0,9'h000,1,9'h1FF,1,0, 0,1,0,0,0,9'h000, 1,0);
    tv[5]  = mk(0,0,9'h000,0,9'h000,1,0, 0,0,1,1,0,9'h000, 1,0);
    tv[6]  = mk(0,0,9'h000,0,9'h000,1,0, 0,0,0,0,1,9'h1FF, 1,0);
    tv[7]  = mk(1,0,9'h000,0,9'h000,1,0, 0,0,0,0,0,9'h000, 1,0);
    tv[8]  = mk(0,1,9'h011,1,9'h122,1,1, 1,0,0,0,0,9'h000, 0,0);
    tv[9]  = mk(0,0,9'h000,1,9'h122,1,1, 0,0,1,0,0,9'h000, 0,0);
    tv[10] = mk(0,0,9'h000,1,9'h122,1,1, 0,0,0,0,1,9'h011, 0,0);
    tv[11] = mk(0,1,9'h044,1,9'h133,0,0, 0,1,0,0,0,9'h000, 1,0);
    for (int k = 12; k <= 15; k++)
      tv[k] = mk(0,1,9'h044,1,9'h0FF,0,0, 0,0,1,1,0,9'h000, 1,0);
    tv[16] = mk(0,1,9'h044,1,9'h0FF,1,0, 0,0,1,1,0,9'h000, 1,0);
    for (int k = 17; k <= 19; k++)
      tv[k] = mk(0,1,9'h044,1,9'h0FF,0,0, 0,0,0,0,1,9'h133, 1,0);
    tv[20] = mk(0,1,9'h044,1,9'h0FF,0,1, 0,0,0,0,1,9'h133, 1,0);
    tv[21] = mk(0,0,9'h000,0,9'h000,1,1, 0,0,0,0,0,9'h000, 1,1);

    reset = 1'b1; in0_valid = 0; in1_valid = 0; in0_data = '0; in1_data = '0;
    s_ready = 1; out_ready = 1;
    w_in0_valid = 0; w_in1_valid = 0; w_in0_data = '0; w_in1_data = '0; w_rdy = 1;
    @(posedge clk); #1;

    for (int k = 0; k < 22; k++) begin
      reset = tv[k].rst; in0_valid = tv[k].i0v; in0_data = tv[k].i0d;
      in1_valid = tv[k].i1v; in1_data = tv[k].i1d;
      s_ready = tv[k].sr; out_ready = tv[k].orr;
      #1;
      chk($sformatf("row%0d in0_ready", k), 32'(in0_ready), 32'(tv[k].e0r));
      chk($sformatf("row%0d in1_ready", k), 32'(in1_ready), 32'(tv[k].e1r));
      chk($sformatf("row%0d s_valid", k),   32'(s_valid),   32'(tv[k].esv));
      chk($sformatf("row%0d s_data", k),    32'(s_data),    32'(tv[k].esd));
      chk($sformatf("row%0d out_valid", k), 32'(out_valid), 32'(tv[k].eov));
      chk($sformatf("row%0d out_data", k),  32'(out_data),  32'(tv[k].eod));
      chk($sformatf("row%0d pkt_cnt0", k),  32'(pkt_cnt0),  32'(tv[k].ec0));
      chk($sformatf("row%0d pkt_cnt1", k),  32'(pkt_cnt1),  32'(tv[k].ec1));
      @(posedge clk); #1;
    end
    chk("out handshakes in table", hs, 3);

    // Contention: both inputs valid continuously after a fresh reset.
    reset = 1; in0_valid = 0; in1_valid = 0; s_ready = 1; out_ready = 1;
    @(posedge clk); #1;
    reset = 0;
    ntok = 0; nout = 0; viol = 0; i0 = 0; i1 = 0;
    in0_valid = 1; in1_valid = 1;
    for (int c = 0; c < 60 && nout < 6; c++) begin
      in0_data = 9'(9'h101 + i0); in1_data = 9'(9'h1F0 + i1);
      #1;
      if (in0_ready && in1_ready) viol++;
      if (s_valid && out_valid) viol++;
      if (in0_ready) i0++;
      if (in1_ready) i1++;
      if (s_valid && ntok < 8) begin tok[ntok] = s_data; ntok++; end
      if (out_valid && nout < 8) begin dat[nout] = out_data; nout++; end
      @(posedge clk); #1;
    end
    in0_valid = 0; in1_valid = 0;
    chk("contention packets", nout, 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("contention token%0d", k), 32'(tok[k]), 32'(k % 2));
      chk($sformatf("contention data%0d", k), 32'(dat[k]),
          (k % 2) ? 32'(9'h1F0 + k / 2) : 32'(9'h101 + k / 2));
    end
    chk("contention exclusivity", viol, 0);
    chk("contention pkt_cnt0", 32'(pkt_cnt0), 3);
    chk("contention pkt_cnt1", 32'(pkt_cnt1), 3);

    // Single active input on in1 while pri favours in0.
    ntok = 0; nout = 0; i1 = 0; n0r = 0; ncyc = 0; viol = 0;
    in1_valid = 1;
    for (int c = 0; c < 40 && nout < 4; c++) begin
      in1_data = 9'(9'h0C0 + i1);
      #1;
      if (in0_ready) n0r++;
      if (in1_ready) i1++;
      if (s_valid && s_data !== 1'b1) viol++;
      if (s_valid) ntok++;
      if (out_valid && nout < 8) begin dat[nout] = out_data; nout++; end
      ncyc++;
      @(posedge clk); #1;
    end
    in1_valid = 0;
    chk("single packets", nout, 4);
    chk("single tokens", ntok, 4);
    chk("single token value", viol, 0);
    chk("single in0_ready", n0r, 0);
    chk("single cycles", ncyc, 12);
    for (int k = 0; k < 4; k++)
      chk($sformatf("single data%0d", k), 32'(dat[k]), 32'(9'h0C0 + k));
    chk("single pkt_cnt1", 32'(pkt_cnt1), 7);

    // Counter wrap on the CNT_W=2 instance.
    nout = 0; w_in0_valid = 1;
    for (int c = 0; c < 40 && nout < 5; c++) begin
      logic done;
      w_in0_data = 9'(9'h050 + nout);
      #1;
      done = w_out_valid;
      @(posedge clk); #1;
      if (done) begin
        chk($sformatf("wrap pkt_cnt0 #%0d", nout), 32'(w_cnt0), 32'((nout + 1) % 4));
        nout++;
      end
    end
    w_in0_valid = 0;
    chk("wrap packets", nout, 5);
    chk("wrap pkt_cnt1", 32'(w_cnt1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/merge2_arb_leaf.md
Name: merge2_arb_leaf

Overview:
- Two-input, one-output merge leaf for the NoC return path; the inverse of the decoder leaf.
- Accepts 9-bit packets from two upstream channels ({addr[8:5], payload[4:0]}) and arbitrates round-robin.
- Emits a 1-bit select token naming the winning input, then forwards the packet unchanged on the single output.
- Clocked valid/ready implementation; packets are never modified, dropped or reordered within an input.

Parameters:
- W, 9, packet width (bits W-1:W-4 address, remainder payload)
- CNT_W, 16, width of per-input packet counters
- INIT_PRI, 0, input favoured first after reset (0 or 1)

Ports:
- clk  input  1  clock, all logic rising-edge
- reset  input  1  synchronous, active-high reset
- in0_data  input  W  packet from input 0
- in0_valid  input  1  input 0 offers packet
- in0_ready  output  1  input 0 accepted this cycle when valid&ready
- in1_data  input  W  packet from input 1
- in1_valid  input  1  input 1 offers packet
- in1_ready  output  1  input 1 handshake
- s_data  output  1  select token: index of winning input
- s_valid  output  1  token offered
- s_ready  input  1  token consumer ready
- out_data  output  W  merged packet
- out_valid  output  1  packet offered
- out_ready  input  1  downstream ready
- pkt_cnt0  output  CNT_W  packets completed from input 0
- pkt_cnt1  output  CNT_W  packets completed from input 1

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, pri=INIT_PRI, captured packet reg=0, captured winner reg=0.
  - in0_ready=in1_ready=0 during the reset cycle.
  - s_valid=0, s_data=0, out_valid=0, out_data=0.
  - pkt_cnt0=pkt_cnt1=0.
- Reset asserted mid-operation abandons any captured packet; it is never emitted.
- FSM states: IDLE, SEND_S, SEND_D.
- IDLE:
  - grant = (in0_valid&in1_valid) ? pri : (in1_valid ? 1 : 0).
  - in0_ready = (grant==0)&in0_valid; in1_ready = (grant==1)&in1_valid. Combinational, never both high.
  - On handshake: capture inX_data and grant into registers, go to SEND_S next cycle.
  - No valid: stay in IDLE.
- SEND_S:
  - s_valid=1, s_data=captured winner; both in*_ready=0.
  - On s_ready, go to SEND_D. Otherwise hold s_data stable.
- SEND_D:
  - out_valid=1, out_data=captured packet, held stable until out_ready.
  - On out_ready: increment pkt_cnt of the winner (wraps modulo 2^CNT_W), set pri = ~winner, go to IDLE.
- The token is always sent before the packet, exactly one token per packet. s_valid and out_valid are never high together.
- Minimum latency: input handshake in cycle N, s_valid in N+1, out_valid in N+2 (with ready high). Peak throughput is 1 packet per 3 cycles.
- Fairness: with both inputs continuously valid, grants alternate 0,1,0,1… starting from INIT_PRI. Priority updates only on packet completion, not on grant.
- A single active input is served back-to-back regardless of pri.
- Input valid dropping while not granted is legal; no state changes.
- in*_data is sampled only on the handshake cycle.

Test Plan:
- Reset then single packet: in0 sends 9'h0A5 with s_ready=out_ready=1.
  - Required: in0_ready in cycle 0, s_valid/s_data=0 in cycle 1, out_valid/out_data=0x0A5 in cycle 2, pkt_cnt0=1.
- Contention: both inputs valid continuously, in0 packets 0x101.., in1 packets 0x1F0.., 6 packets.
  - Required: s_data sequence 0,1,0,1,0,1 with matching data order; pkt_cnt0=pkt_cnt1=3.
- Backpressure: s_ready=0 for 4 cycles, then out_ready=0 for 3 cycles.
  - Required: s_data, out_data and the captured packet stay stable; no in*_ready asserted; exactly one output handshake.
- Single active input: 4 packets on in1 only.
  - Required: all granted to in1, s_data=1 each time, no in0_ready.
- Reset in SEND_D holding 0x1FF.
  - Required: next cycle out_valid=0, counters=0, packet never appears; first post-reset packet arbitrated with pri=INIT_PRI.
- Counter wrap with CNT_W=2: 5 packets on in0.
  - Required: pkt_cnt0 reads 1,2,3,0,1.
